io_serdes_link_ctrl: RTL and testbench

Bring-up sequencer for the IO serdes configuration port. After `start`, it acts as AXI-Lite master to the serdes register block. It writes rxen, waits a programmable settle delay, then writes txen+rxen. It reads offset 0 back to verify, then waits for the remote side to deliver data. It reports link_up or link_err to the surrounding FSIC control logic and gates cc_ls_enable so the serdes only sees AXI-Lite traffic while the sequencer owns it.

---
 rtl/io_serdes_link_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_io_serdes_link_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_serdes_link_ctrl.sv
// Bring-up sequencer for the IO serdes configuration port.
// Acts as AXI-Lite master: writes rxen, waits a settle delay, writes txen+rxen,
// reads offset 0 back, then waits for remote data before reporting link status.
module io_serdes_link_ctrl #(
    parameter int unsigned pADDR_WIDTH = 10,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pRX_DLY     = 16,
    parameter int unsigned pTIMEOUT    = 1024,
    parameter int unsigned pCNT_WIDTH  = 16
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset,
    input  logic                       start,
    input  logic                       link_rx_seen,
    output logic                       cc_ls_enable,
    output logic                       axi_awvalid,
    output logic [pADDR_WIDTH-1:0]     axi_awaddr,
    input  logic                       axi_awready,
    output logic                       axi_wvalid,
    output logic [pDATA_WIDTH-1:0]     axi_wdata,
    output logic [pDATA_WIDTH/8-1:0]   axi_wstrb,
    input  logic                       axi_wready,
    output logic                       axi_arvalid,
    output logic [pADDR_WIDTH-1:0]     axi_araddr,
    input  logic                       axi_arready,
    input  logic                       axi_rvalid,
    input  logic [pDATA_WIDTH-1:0]     axi_rdata,
    output logic                       axi_rready,
    output logic                       link_up,
    output logic                       link_err,
    output logic [1:0]                 err_code,
    output logic [2:0]                 state
);

    localparam int unsigned STRB_W = pDATA_WIDTH / 8;
    localparam logic [pCNT_WIDTH-1:0] DLY_LAST = pCNT_WIDTH'(pRX_DLY - 1);
    localparam logic [pCNT_WIDTH-1:0] TMO_LAST = pCNT_WIDTH'(pTIMEOUT - 1);

    // UP and ERR both report 7 on the debug port; ERR needs a distinct internal code.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_RXEN   = 4'd1,
        S_WAIT_DLY  = 4'd2,
        S_WR_TXEN   = 4'd3,
        S_RD_ADDR   = 4'd4,
        S_RD_DATA   = 4'd5,
        S_WAIT_LINK = 4'd6,
        S_UP        = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [pCNT_WIDTH-1:0]   r_cnt;
    logic [pCNT_WIDTH-1:0]   w_cnt_nxt;
    logic                    w_tmo;
    logic                    w_dly_done;
    logic                    w_counting;

    logic                    r_cc_ls_enable, w_cc_ls_enable;
    logic                    r_awvalid,      w_awvalid;
    logic                    r_wvalid,       w_wvalid;
    logic [pDATA_WIDTH-1:0]  r_wdata,        w_wdata;
    logic [STRB_W-1:0]       r_wstrb,        w_wstrb;
    logic                    r_arvalid,      w_arvalid;
    logic                    r_rready,       w_rready;
    logic                    r_link_up,      w_link_up;
    logic                    r_link_err,     w_link_err;
    logic [1:0]              r_err_code,     w_err_code;
    logic [2:0]              r_state_dbg,    w_state_dbg;

    // Only the enable bits of the readback are checked.
    logic w_unused_rdata;
    assign w_unused_rdata = &{1'b0, axi_rdata[pDATA_WIDTH-1:2]};

    assign w_tmo      = (r_cnt == TMO_LAST);
    assign w_dly_done = (r_cnt == DLY_LAST);
    assign w_counting = (r_state != S_IDLE) && (r_state != S_UP) && (r_state != S_ERR);
    assign w_cnt_nxt  = ((w_next != r_state) || !w_counting) ? '0 : r_cnt + pCNT_WIDTH'(1);

    // State register and shared delay/timeout counter.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode; exit conditions take priority over timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_WR_RXEN;
            S_WR_RXEN: begin
                if (axi_awready && axi_wready) w_next = S_WAIT_DLY;
                else if (w_tmo)                w_next = S_ERR;
            end
            S_WAIT_DLY:  if (w_dly_done) w_next = S_WR_TXEN;
            S_WR_TXEN: begin
                if (axi_awready && axi_wready) w_next = S_RD_ADDR;
                else if (w_tmo)                w_next = S_ERR;
            end
            S_RD_ADDR: begin
                if (axi_arready)  w_next = S_RD_DATA;
                else if (w_tmo)   w_next = S_ERR;
            end
            S_RD_DATA: begin
                if (axi_rvalid)   w_next = (axi_rdata[1:0] == 2'b11) ? S_WAIT_LINK : S_ERR;
                else if (w_tmo)   w_next = S_ERR;
            end
            S_WAIT_LINK: begin
                if (link_rx_seen) w_next = S_UP;
                else if (w_tmo)   w_next = S_ERR;
            end
            S_UP:        w_next = S_UP;
            S_ERR:       if (start) w_next = S_WR_RXEN;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track the state.
    always_comb begin
        w_cc_ls_enable = 1'b0;
        w_awvalid      = 1'b0;
        w_wvalid       = 1'b0;
        w_wdata        = '0;
        w_wstrb        = '0;
        w_arvalid      = 1'b0;
        w_rready       = 1'b0;
        w_link_up      = (w_next == S_UP);
        w_link_err     = (w_next == S_ERR);
        w_err_code     = 2'd0;
        w_state_dbg    = (w_next == S_ERR) ? 3'd7 : w_next[2:0];
        case (w_next)
            S_WR_RXEN: begin
                w_cc_ls_enable = 1'b1;
                w_awvalid      = 1'b1;
                w_wvalid       = 1'b1;
                w_wdata        = pDATA_WIDTH'(1);
                w_wstrb        = STRB_W'(1);
            end
            S_WR_TXEN: begin
                w_cc_ls_enable = 1'b1;
                w_awvalid      = 1'b1;
                w_wvalid       = 1'b1;
                w_wdata        = pDATA_WIDTH'(3);
                w_wstrb        = STRB_W'(1);
            end
            S_RD_ADDR: begin
                w_cc_ls_enable = 1'b1;
                w_arvalid      = 1'b1;
            end
            S_RD_DATA: begin
                w_cc_ls_enable = 1'b1;
                w_rready       = 1'b1;
            end
            default: ;
        endcase
        if (w_next == S_ERR) begin
            if (r_state == S_ERR)                         w_err_code = r_err_code;
            else if (r_state == S_WAIT_LINK)              w_err_code = 2'd3;
            else if ((r_state == S_RD_DATA) && axi_rvalid) w_err_code = 2'd2;
            else                                          w_err_code = 2'd1;
        end
    end

    // Output registers.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_cc_ls_enable <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_link_up      <= 1'b0;
            r_link_err     <= 1'b0;
            r_err_code     <= 2'd0;
            r_state_dbg    <= 3'd0;
        end else begin
            r_cc_ls_enable <= w_cc_ls_enable;
            r_awvalid      <= w_awvalid;
            r_wvalid       <= w_wvalid;
            r_wdata        <= w_wdata;
            r_wstrb        <= w_wstrb;
            r_arvalid      <= w_arvalid;
            r_rready       <= w_rready;
            r_link_up      <= w_link_up;
            r_link_err     <= w_link_err;
            r_err_code     <= w_err_code;
            r_state_dbg    <= w_state_dbg;
        end
    end

    assign cc_ls_enable = r_cc_ls_enable;
    assign axi_awvalid  = r_awvalid;
    assign axi_awaddr   = '0;
    assign axi_wvalid   = r_wvalid;
    assign axi_wdata    = r_wdata;
    assign axi_wstrb    = r_wstrb;
    assign axi_arvalid  = r_arvalid;
    assign axi_araddr   = '0;
    assign axi_rready   = r_rready;
    assign link_up      = r_link_up;
    assign link_err     = r_link_err;
    assign err_code     = r_err_code;
    assign state        = r_state_dbg;

endmodule

// File: tb/tb_io_serdes_link_ctrl.sv
// Self-checking bench for io_serdes_link_ctrl: reactive AXI-Lite slave with
// per-transaction stall counts and a transaction-level timing/outcome model.
module tb_io_serdes_link_ctrl;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned DLY = 16;
    localparam int unsigned TMO = 64;

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic          start = 1'b0;
    logic          link_rx_seen = 1'b0;
    logic          cc_ls_enable;
    logic          axi_awvalid;
    logic [AW-1:0] axi_awaddr;
    logic          axi_awready = 1'b0;
    logic          axi_wvalid;
    logic [DW-1:0] axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wready = 1'b0;
    logic          axi_arvalid;
    logic [AW-1:0] axi_araddr;
    logic          axi_arready = 1'b0;
    logic          axi_rvalid = 1'b0;
    logic [DW-1:0] axi_rdata = '0;
    logic          axi_rready;
    logic          link_up;
    logic          link_err;
    logic [1:0]    err_code;
    logic [2:0]    state;

    io_serdes_link_ctrl #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRX_DLY(DLY),
        .pTIMEOUT(TMO), .pCNT_WIDTH(16)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start),
        .link_rx_seen(link_rx_seen), .cc_ls_enable(cc_ls_enable),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wready(axi_wready), .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr),
        .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .axi_rready(axi_rready), .link_up(link_up), .link_err(link_err),
        .err_code(err_code), .state(state)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration: ready index within each transaction (cycles of stall).
    int          aw_d[2];
    int          w_d[2];
    int          ar_d;
    int          r_d;
    int          lk_d;
    logic [31:0] rd_val;

    // Transaction logs.
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    logic [9:0]  wa_q[$];
    int          vc_q[$];
    logic [9:0]  ra_q[$];
    int          rd_cnt = 0;
    int          stab_bad = 0;
    int          wv_cyc = 0;

    int          wcnt = 0, acnt = 0, rcnt = 0, lcnt = 0;
    logic [31:0] wcap;

    // Reactive slave and remote link, driven away from the active edge.
    always @(negedge axi_clk) begin
        int idx;
        idx = (wd_q.size() > 0) ? 1 : 0;
        if (axi_awvalid) begin
            axi_awready = (wcnt >= aw_d[idx]);
            axi_wready  = (wcnt >= w_d[idx]);
            if (wcnt == 0) wcap = axi_wdata;
            else if (axi_wdata !== wcap || axi_awaddr !== '0 || axi_wvalid !== 1'b1) stab_bad++;
            wcnt++;
        end else begin
            axi_awready = 1'b0;
            axi_wready  = 1'b0;
            wcnt = 0;
        end
        if (axi_arvalid) begin
            axi_arready = (acnt >= ar_d);
            acnt++;
        end else begin
            axi_arready = 1'b0;
            acnt = 0;
        end
        if (axi_rready) begin
            axi_rvalid = (rcnt >= r_d);
            axi_rdata  = rd_val;
            rcnt++;
        end else begin
            axi_rvalid = 1'b0;
            rcnt = 0;
        end
        if (state == 3'd6) begin
            link_rx_seen = (lcnt >= lk_d);
            lcnt++;
        end else begin
            link_rx_seen = 1'b0;
            lcnt = 0;
        end
    end

    // Handshake recorder.
    always @(posedge axi_clk) begin
        if (axi_reset) begin
            wv_cyc = 0;
        end else begin
            if (axi_awvalid) wv_cyc++;
            if (axi_awvalid && axi_awready && axi_wvalid && axi_wready) begin
                wd_q.push_back(axi_wdata);
                ws_q.push_back(axi_wstrb);
                wa_q.push_back(axi_awaddr);
                vc_q.push_back(wv_cyc);
                wv_cyc = 0;
            end
            if (axi_arvalid && axi_arready) ra_q.push_back(axi_araddr);
            if (axi_rready && axi_rvalid) rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outcome model: each phase lasts (stall+1) cycles unless the stall reaches the timeout.
    task automatic model(output int edge_n, output bit up, output logic [1:0] code,
                         output int nw, output int nr);
        int t;
        int d;
        t = 0; up = 0; code = 2'd0; nw = 0; nr = 0; edge_n = 0;
        d = (aw_d[0] > w_d[0]) ? aw_d[0] : w_d[0];
        if (d >= TMO) begin edge_n = t + TMO; code = 2'd1; return; end
        t += d + 1 + DLY; nw = 1;
        d = (aw_d[1] > w_d[1]) ? aw_d[1] : w_d[1];
        if (d >= TMO) begin edge_n = t + TMO; code = 2'd1; return; end
        t += d + 1; nw = 2;
        if (ar_d >= TMO) begin edge_n = t + TMO; code = 2'd1; return; end
        t += ar_d + 1;
        if (r_d >= TMO) begin edge_n = t + TMO; code = 2'd1; return; end
        t += r_d + 1; nr = 1;
        if (rd_val[1:0] != 2'b11) begin edge_n = t; code = 2'd2; return; end
        if (lk_d >= TMO) begin edge_n = t + TMO; code = 2'd3; return; end
        t += lk_d + 1; up = 1; edge_n = t;
    endtask

    task automatic clear_logs();
        wd_q.delete(); ws_q.delete(); wa_q.delete(); vc_q.delete(); ra_q.delete();
        rd_cnt = 0; stab_bad = 0;
    endtask

    task automatic set_cfg(input int a0, input int w0, input int a1, input int w1,
                           input int ar, input int r, input logic [31:0] rv, input int lk);
        aw_d[0] = a0; w_d[0] = w0; aw_d[1] = a1; w_d[1] = w1;
        ar_d = ar; r_d = r; rd_val = rv; lk_d = lk;
    endtask

    task automatic do_reset();
        @(negedge axi_clk); axi_reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk); axi_reset = 1'b0;
        clear_logs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cc_ls"},   32'(cc_ls_enable), 32'h0);
        chk({tag, ".awvalid"}, 32'(axi_awvalid),  32'h0);
        chk({tag, ".wvalid"},  32'(axi_wvalid),   32'h0);
        chk({tag, ".wdata"},   axi_wdata,         32'h0);
        chk({tag, ".wstrb"},   32'(axi_wstrb),    32'h0);
        chk({tag, ".arvalid"}, 32'(axi_arvalid),  32'h0);
        chk({tag, ".rready"},  32'(axi_rready),   32'h0);
        chk({tag, ".link_up"}, 32'(link_up),      32'h0);
        chk({tag, ".link_err"},32'(link_err),     32'h0);
        chk({tag, ".err_code"},32'(err_code),     32'h0);
        chk({tag, ".state"},   32'(state),        32'h0);
        chk({tag, ".awaddr"},  32'(axi_awaddr),   32'h0);
        chk({tag, ".araddr"},  32'(axi_araddr),   32'h0);
    endtask

    // Pulse start, run to a terminal status, and compare against the model.
    task automatic run_seq(input string tag, input bit spur);
        int  exp_edge, nw, nr, n;
        bit  exp_up;
        logic [1:0] exp_code;
        model(exp_edge, exp_up, exp_code, nw, nr);
        clear_logs();
        @(negedge axi_clk); start = 1'b1;
        @(posedge axi_clk); #1; start = 1'b0;
        chk({tag, ".e0.state"},   32'(state),        32'd1);
        chk({tag, ".e0.awvalid"}, 32'(axi_awvalid),  32'd1);
        chk({tag, ".e0.wvalid"},  32'(axi_wvalid),   32'd1);
        chk({tag, ".e0.wdata"},   axi_wdata,         32'd1);
        chk({tag, ".e0.cc_ls"},   32'(cc_ls_enable), 32'd1);
        chk({tag, ".e0.link_err"},32'(link_err),     32'd0);
        chk({tag, ".e0.err_code"},32'(err_code),     32'd0);
        for (n = 1; n <= 400; n++) begin
            @(posedge axi_clk); #1;
            if (spur && n == 5) start = 1'b1;
            if (spur && n == 6) start = 1'b0;
            if (link_up || link_err) break;
        end
        start = 1'b0;
        chk({tag, ".edge"},     32'(n),           32'(exp_edge));
        chk({tag, ".link_up"},  32'(link_up),     32'(exp_up));
        chk({tag, ".link_err"}, 32'(link_err),    32'(!exp_up));
        chk({tag, ".err_code"}, 32'(err_code),    32'(exp_code));
        chk({tag, ".state"},    32'(state),       32'd7);
        chk({tag, ".cc_ls"},    32'(cc_ls_enable),32'd0);
        chk({tag, ".valids"},   32'({axi_awvalid, axi_wvalid, axi_arvalid, axi_rready}), 32'd0);
        chk({tag, ".nwrites"},  32'(wd_q.size()), 32'(nw));
        chk({tag, ".nreads"},   32'(rd_cnt),      32'(nr));
        chk({tag, ".stable"},   32'(stab_bad),    32'd0);
        for (int i = 0; i < wd_q.size(); i++) begin
            chk($sformatf("%s.wdata%0d", tag, i), wd_q[i], (i == 0) ? 32'd1 : 32'd3);
            chk($sformatf("%s.wstrb%0d", tag, i), 32'(ws_q[i]), 32'd1);
            chk($sformatf("%s.awaddr%0d", tag, i), 32'(wa_q[i]), 32'd0);
        end
        for (int i = 0; i < ra_q.size(); i++)
            chk($sformatf("%s.araddr%0d", tag, i), 32'(ra_q[i]), 32'd0);
    endtask

    initial begin
        set_cfg(0, 0, 0, 0, 0, 0, 32'h3, 0);
        repeat (3) @(posedge axi_clk);
        #1;
        chk_all_zero("reset");
        @(negedge axi_clk); axi_reset = 1'b0;

        // Nominal, always-ready slave.
        run_seq("nominal", 1'b0);

        // Spurious start during WAIT_DLY, then in UP.
        do_reset();
        run_seq("spur", 1'b1);
        @(negedge axi_clk); start = 1'b1;
        @(negedge axi_clk); start = 1'b0;
        repeat (5) @(posedge axi_clk);
        #1;
        chk("spur_up.link_up", 32'(link_up), 32'd1);
        chk("spur_up.state",   32'(state),   32'd7);
        chk("spur_up.nwrites", 32'(wd_q.size()), 32'd2);

        // Write backpressure: awready early, wready 5 cycles late.
        do_reset();
        set_cfg(0, 5, 0, 0, 0, 0, 32'h3, 0);
        run_seq("bp", 1'b0);
        if (vc_q.size() > 0) chk("bp.valid_cycles", 32'(vc_q[0]), 32'd6);
        else chk("bp.valid_cycles_missing", 32'(vc_q.size()), 32'd1);

        // Readback mismatch, quiet bus, then restart from ERR.
        do_reset();
        set_cfg(0, 0, 0, 0, 0, 0, 32'h1, 0);
        run_seq("mismatch", 1'b0);
        repeat (10) @(posedge axi_clk);
        #1;
        chk("mismatch.quiet_writes", 32'(wd_q.size()), 32'd2);
        chk("mismatch.quiet_reads",  32'(rd_cnt),      32'd1);
        chk("mismatch.quiet_valids", 32'({axi_awvalid, axi_arvalid, axi_rready, cc_ls_enable}), 32'd0);
        chk("mismatch.hold_err",     32'({link_err, err_code}), 32'h6);
        rd_val = 32'hFFFF_FFF7;
        run_seq("restart", 1'b0);

        // Link timeout, same-cycle win from ERR, and exact timeout from IDLE.
        do_reset();
        set_cfg(0, 0, 0, 0, 0, 0, 32'h3, 1000);
        run_seq("link_tmo", 1'b0);
        lk_d = TMO - 1;
        run_seq("link_edge", 1'b0);
        do_reset();
        lk_d = TMO;
        run_seq("link_tmo2", 1'b0);

        // Write handshake timeout.
        do_reset();
        set_cfg(0, 200, 0, 0, 0, 0, 32'h3, 0);
        run_seq("wr_tmo", 1'b0);

        // Read data handshake timeout.
        do_reset();
        set_cfg(0, 0, 0, 0, 0, 200, 32'h3, 0);
        run_seq("rd_tmo", 1'b0);

        // Reset during a stalled write.
        do_reset();
        set_cfg(200, 200, 0, 0, 0, 0, 32'h3, 0);
        @(negedge axi_clk); start = 1'b1;
        @(negedge axi_clk); start = 1'b0;
        repeat (2) @(negedge axi_clk);
        chk("rst_mid.awvalid_before", 32'(axi_awvalid), 32'd1);
        axi_reset = 1'b1;
        @(posedge axi_clk); #1;
        chk_all_zero("rst_mid");
        @(negedge axi_clk); axi_reset = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 32'h3, 0);
        run_seq("after_rst", 1'b0);

        // Randomized stalls, readback values and link delay.
        for (int it = 0; it < 8; it++) begin
            logic [31:0] rv;
            rv = $urandom;
            if ($urandom_range(3) != 0) rv[1:0] = 2'b11;
            do_reset();
            set_cfg(int'($urandom_range(7)), int'($urandom_range(7)),
                    int'($urandom_range(7)), int'($urandom_range(7)),
                    int'($urandom_range(7)), int'($urandom_range(7)),
                    rv, int'($urandom_range(15)));
            run_seq($sformatf("rand%0d", it), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
